// File: rtl/median_pkg.sv
// Shared constants and state encoding for the median filter window feeder.
package median_pkg;
    localparam int DEF_PIX_W = 8;
    localparam int WIN_N     = 9;

    typedef enum logic {
        ACCEPT,
        SEND
    } state_t;
endpackage

// File: rtl/median_line_buffer.sv
// One image row of pixel storage; read returns the addressed entry in the same cycle.
module median_line_buffer #(
    parameter int IMG_W = 64,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(IMG_W)-1:0] addr,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [PIX_W-1:0]         rd_data
);
    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Old contents are needed at the write address in the write cycle.
    assign rd_data = mem[addr];
endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 neighbourhoods from a raster pixel stream and sends them serially.
// Optional WIN_POS_EN adds the win_x/win_y window-centre position ports.
module median_window_feeder
    import median_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic [PIX_W-1:0] win_data,
    output logic             win_valid,
    output logic             win_last,
`ifdef WIN_POS_EN
    output logic [15:0]      win_x,
    output logic [15:0]      win_y,
`endif
    input  logic             win_ready
);
    localparam int              COL_W    = $clog2(IMG_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [3:0]      LAST_IDX = 4'(WIN_N - 1);

    state_t                         state_reg;
    logic [COL_W-1:0]               col_reg;
    logic [COL_W-1:0]               col_cur;
    logic [1:0]                     row_reg;
    logic [1:0]                     row_cur;
    logic [3:0]                     idx_reg;
    logic [3:0]                     idx_next;
    logic [PIX_W-1:0]               data_reg;
    logic                           last_reg;
    logic [WIN_N-1:0][PIX_W-1:0]    win_reg;
    logic [WIN_N-1:0][PIX_W-1:0]    win_next;
    logic [PIX_W-1:0]               lb0_rd;
    logic [PIX_W-1:0]               lb1_rd;
    logic                           xfer;
    logic                           trigger;
    logic                           wrap;

    // A start-of-frame pixel is placed at column 0, row 0 regardless of the counters.
    assign col_cur  = pix_sof ? '0 : col_reg;
    assign row_cur  = pix_sof ? '0 : row_reg;
    assign xfer     = pix_valid && (state_reg == ACCEPT);
    assign wrap     = (col_cur == LAST_COL);
    assign trigger  = xfer && (row_cur == 2'd2) && (col_cur >= COL_W'(2));
    assign idx_next = idx_reg + 4'd1;

    assign pix_ready = (state_reg == ACCEPT);
    assign win_valid = (state_reg == SEND);
    assign win_data  = data_reg;
    assign win_last  = last_reg;

    median_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (xfer),
        .addr    (col_cur),
        .wr_data (pix_in),
        .rd_data (lb0_rd)
    );

    median_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (xfer),
        .addr    (col_cur),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Window rows shift left; right column is {oldest line, previous line, incoming pixel}.
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        assign win_next[gi*3 + 0] = win_reg[gi*3 + 1];
        assign win_next[gi*3 + 1] = win_reg[gi*3 + 2];
        if (gi == 0) begin : g_top
            assign win_next[gi*3 + 2] = lb1_rd;
        end else if (gi == 1) begin : g_mid
            assign win_next[gi*3 + 2] = lb0_rd;
        end else begin : g_bot
            assign win_next[gi*3 + 2] = pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACCEPT;
            col_reg   <= '0;
            row_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
            win_reg   <= '0;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (xfer) begin
                        win_reg <= win_next;
                        if (wrap) begin
                            col_reg <= '0;
                            row_reg <= (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
                        end else begin
                            col_reg <= col_cur + COL_W'(1);
                            row_reg <= row_cur;
                        end
                        if (trigger) begin
                            state_reg <= SEND;
                            idx_reg   <= '0;
                            data_reg  <= win_next[0];
                            last_reg  <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (win_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= ACCEPT;
                            idx_reg   <= '0;
                            last_reg  <= 1'b0;
                        end else begin
                            idx_reg  <= idx_next;
                            data_reg <= win_reg[idx_next];
                            last_reg <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state_reg <= ACCEPT;
            endcase
        end
    end

`ifdef WIN_POS_EN
    logic [15:0] y_reg;
    logic [15:0] y_cur;
    logic [15:0] x_out_reg;
    logic [15:0] y_out_reg;

    assign y_cur = pix_sof ? 16'd0 : y_reg;
    assign win_x = x_out_reg;
    assign win_y = y_out_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            y_reg     <= '0;
            x_out_reg <= '0;
            y_out_reg <= '0;
        end else if (xfer) begin
            if (wrap) begin
                y_reg <= y_cur + 16'd1;
            end else begin
                y_reg <= y_cur;
            end
            if (trigger) begin
                x_out_reg <= 16'(col_cur) - 16'd1;
                y_out_reg <= y_cur - 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench: an image-array model predicts every window element; a monitor pops and compares.
module tb_median_window_feeder;
    import median_pkg::*;

    localparam int IMG_W = 4;
    localparam int PIX_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_valid = 1'b0;
    logic             pix_sof = 1'b0;
    logic             pix_ready;
    logic [PIX_W-1:0] win_data;
    logic             win_valid;
    logic             win_last;
    logic             win_ready = 1'b1;
`ifdef WIN_POS_EN
    logic [15:0]      win_x;
    logic [15:0]      win_y;
`endif

    median_window_feeder #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_last  (win_last),
`ifdef WIN_POS_EN
        .win_x     (win_x),
        .win_y     (win_y),
`endif
        .win_ready (win_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int last;
        int x;
        int y;
    } elem_t;

    elem_t exp_q[$];
    int    got_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    rdy_mode = 0;
    int    stall_left = 0;
    int    win_elem = 0;
    int    n_win = 0;
    int    mx = 0;
    int    my = 0;
    bit    last_trig = 1'b0;
    logic [7:0] img [0:255][0:IMG_W-1];

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    // Reference: place the pixel in a 2-D image and emit the 3x3 block ending at it.
    function automatic void model_accept(input logic [7:0] p, input bit sof);
        if (sof) begin
            mx = 0;
            my = 0;
        end
        img[my % 256][mx] = p;
        last_trig = (mx >= 2 && my >= 2);
        if (last_trig) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    elem_t e;
                    e.data = int'(img[(my - 2 + r) % 256][mx - 2 + c]);
                    e.last = (r == 2 && c == 2) ? 1 : 0;
                    e.x    = mx - 1;
                    e.y    = my - 1;
                    exp_q.push_back(e);
                end
            end
        end
        mx++;
        if (mx == IMG_W) begin
            mx = 0;
            my++;
        end
    endfunction

    task automatic send_pix(input logic [7:0] p, input bit sof);
        int waits;
        waits = 0;
        pix_in = p;
        pix_sof = sof;
        pix_valid = 1'b1;
        while (!pix_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!pix_ready) begin
            chk("pix_ready_timeout", int'(pix_ready), 1);
            pix_valid = 1'b0;
            pix_sof = 1'b0;
            return;
        end
        if (last_trig && rdy_mode == 0) chk("window_cycles", waits, 9);
        model_accept(p, sof);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_in = 8'($urandom);
        if (last_trig) begin
            chk("first_elem_latency", int'(win_valid), 1);
            chk("pix_ready_in_send", int'(pix_ready), 0);
        end
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(negedge clk);
        last_trig = 1'b0;
    endtask

    task automatic frame(input int first, input int n, input bit rnd, input bit gaps);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = rnd ? 8'($urandom) : 8'(first + i);
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_pix(p, i == 0);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        #1;
        while ((exp_q.size() != 0 || win_valid) && c < 300) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        last_trig = 1'b0;
    endtask

    // Monitor: drives win_ready, then samples the output for the coming clock edge.
    initial begin
        elem_t e;
        bit    stalled_prev;
        int    prev_data;
        int    prev_last;
        stalled_prev = 1'b0;
        prev_data = 0;
        prev_last = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1: win_ready = ($urandom_range(0, 3) != 0);
                2: win_ready = !(win_elem == 4 && stall_left > 0 && exp_q.size() > 0);
                default: win_ready = 1'b1;
            endcase
            if (reset) begin
                stalled_prev = 1'b0;
            end else begin
                if (rdy_mode == 2 && !win_ready) begin
                    stall_left--;
                    chk("stall_valid", int'(win_valid), 1);
                    chk("stall_data", int'(win_data), exp_q[0].data);
                end
                if (win_valid) begin
                    chk("ready_exclusive", int'(pix_ready), 0);
                    if (stalled_prev) begin
                        chk("hold_data", int'(win_data), prev_data);
                        chk("hold_last", int'(win_last), prev_last);
                    end
                    if (win_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_element_queue", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("win_data", int'(win_data), e.data);
                            chk("win_last", int'(win_last), e.last);
`ifdef WIN_POS_EN
                            chk("win_x", int'(win_x), e.x);
                            chk("win_y", int'(win_y), e.y);
`endif
                            got_q.push_back(int'(win_data));
                            win_elem++;
                            if (e.last != 0) begin
                                win_elem = 0;
                                n_win++;
                            end
                        end
                    end
                end
                stalled_prev = win_valid && !win_ready;
                prev_data = int'(win_data);
                prev_last = int'(win_last);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_exp[18];
        int base;
        int waited;
        t1_exp = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 2, 3, 4, 6, 7, 8, 10, 11, 12};

        repeat (3) @(negedge clk);
        chk("reset_pix_ready", int'(pix_ready), 1);
        chk("reset_win_valid", int'(win_valid), 0);
        chk("reset_win_last", int'(win_last), 0);
        chk("reset_win_data", int'(win_data), 0);
`ifdef WIN_POS_EN
        chk("reset_win_x", int'(win_x), 0);
        chk("reset_win_y", int'(win_y), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Basic frame 1..12 with the consumer always ready.
        rdy_mode = 0;
        got_q.delete();
        base = n_win;
        frame(1, 12, 1'b0, 1'b0);
        drain();
        chk("t1_window_count", n_win - base, 2);
        chk("t1_element_count", got_q.size(), 18);
        for (int i = 0; i < 18 && i < got_q.size(); i++) chk("t1_element", got_q[i], t1_exp[i]);

        // Same frame with a 3-cycle stall at element 4 of the first window.
        rdy_mode = 2;
        stall_left = 3;
        base = n_win;
        frame(1, 12, 1'b0, 1'b0);
        drain();
        chk("t2_stall_taken", stall_left, 0);
        chk("t2_window_count", n_win - base, 2);
        rdy_mode = 0;

        // Pixel 99 offered during SEND is held off, then consumed.
        base = n_win;
        frame(1, 11, 1'b0, 1'b0);
        send_pix(8'd99, 1'b0);
        drain();
        chk("t3_window_count", n_win - base, 2);

        // Start of frame restarted on pixel 7.
        base = n_win;
        frame(1, 6, 1'b0, 1'b0);
        frame(7, 16, 1'b0, 1'b0);
        drain();
        chk("t4_window_count", n_win - base, 4);

        // Reset part-way through a window, then a clean frame.
        frame(21, 11, 1'b0, 1'b0);
        waited = 0;
        while (win_elem != 6 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("t5_reached_idx5", win_elem, 6);
        reset = 1'b1;
        exp_q.delete();
        win_elem = 0;
        mx = 0;
        my = 0;
        last_trig = 1'b0;
        @(negedge clk);
        chk("t5_abort_valid", int'(win_valid), 0);
        chk("t5_abort_last", int'(win_last), 0);
        chk("t5_abort_ready", int'(pix_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        base = n_win;
        frame(0, 12, 1'b1, 1'b0);
        drain();
        chk("t5_window_count", n_win - base, 2);

        // Randomized frames with random back-pressure and input gaps.
        rdy_mode = 1;
        for (int f = 0; f < 6; f++) begin
            int rows;
            rows = $urandom_range(3, 6);
            base = n_win;
            frame(0, rows * IMG_W, 1'b1, 1'b1);
            drain();
            chk("rand_window_count", n_win - base, (IMG_W - 2) * (rows - 2));
        end
        rdy_mode = 0;
        idle(4);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Producer side of the median filter path: accepts a raster-order 8-bit pixel stream, keeps two line buffers, and forms a 3x3 neighbourhood for every interior pixel. Each neighbourhood is sent as nine serial pixels, row-major, over a valid/ready handshake to the median sorting stage. The input is back-pressured while a window is being sent.

## Interface
- IMG_W, 64: pixels per image row; must be at least 3.
- PIX_W, 8: pixel width in bits.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pix_in  in  PIX_W  input pixel.
- pix_valid  in  1  pix_in is valid.
- pix_sof  in  1  start of frame; qualified by a pix_valid && pix_ready transfer.
- pix_ready  out  1  block can accept a pixel.
- win_data  out  PIX_W  current window element.
- win_valid  out  1  win_data is valid.
- win_last  out  1  ninth (final) element of a window.
- win_ready  in  1  downstream accepts the element.
- win_x, win_y  out  16 each  column and row of the window centre (only when WIN_POS_EN is defined).

## Operation
- Two states: ACCEPT and SEND.
- ACCEPT
  - pix_ready=1, win_valid=0.
  - Input transfer = pix_valid && pix_ready.
  - On a transfer: lb1[col]<=lb0[col], lb0[col]<=pix_in.
  - The 3x3 window register shifts left one column; the new right column is {lb1[col], lb0[col], pix_in} (top, middle, bottom).
- Counters
  - col wraps from IMG_W-1 to 0; row increments on each wrap and saturates at 2.
  - An internal full row counter drives win_y.
- Window trigger
  - If row>=2 and col>=2 at the transfer, go to SEND with idx=0 and snapshot the window.
  - Otherwise stay in ACCEPT.
- SEND
  - pix_ready=0, win_valid=1, win_data=win[idx], where idx 0..8 walks top-left to bottom-right, row-major.
  - win_last = (idx==8).
  - On win_valid && win_ready: idx increments. If idx==8, return to ACCEPT.
  - With win_ready held high, a full window takes exactly 9 cycles.
- pix_sof
  - On a transfer with pix_sof=1, treat the pixel as col=0, row=0 and set the position counters to that pixel.
  - Line buffer contents are not cleared; they are overwritten before use.
- Border pixels (row<2 or col<2) produce no window.
  - Per frame: (IMG_W-2) x (H-2) windows for H rows.
- Arithmetic
  - Counters are unsigned and wide enough for IMG_W-1.
  - No pixel arithmetic is performed.

## Timing
- Reset values
  - State=ACCEPT; col, row, idx = 0.
  - pix_ready=1; win_valid=0, win_last=0, win_data=0.
  - win_x=0 and win_y=0.
- Latency
  - The first element is valid in the cycle after the triggering input transfer.
  - pix_ready returns high in the cycle after the transfer of the 9th element.
- While win_valid=1 and win_ready=0, win_data, win_last and win_x/win_y stay stable.
- The snapshot is held for the whole SEND state.
- pix_valid during SEND is ignored; pix_ready=0, so no transfer takes place.
- Reset asserted during SEND aborts the window. The next cycle follows the reset values, and no partial window resumes.

## Configuration
- WIN_POS_EN defined:
  - win_x and win_y are present. In SEND they equal the centre coordinates (col-1, row-1 relative to the triggering pixel).
  - They hold their value in ACCEPT.
- WIN_POS_EN undefined:
  - The ports and the full row counter are absent.
  - All other behaviour is identical.

## Structure
- Package median_pkg:
  - PIX_W default.
  - WIN_N=9.
  - State enum {ACCEPT, SEND}.
- Sub-module median_line_buffer:
  - One instance per row.
  - IMG_W x PIX_W single-port memory.
  - Synchronous write, and a read of the addressed entry in the same cycle that matches the column-shift timing.
- All control (FSM, counters, window register) lives in the top module.

## Test plan
- Frame with IMG_W=4 and 3 rows, pixels 1..12, win_ready=1:
  - Window 1 is 1,2,3,5,6,7,9,10,11, with win_last on 11.
  - Window 2 is 2,3,4,6,7,8,10,11,12.
  - No other windows are produced.
- Same frame with win_ready=0 for 3 cycles at idx 4: win_data holds 6 and win_valid stays 1 throughout. The window then completes normally.
- During SEND, pix_valid=1 with pix_in=99: pix_ready=0 and 99 is not consumed. It is consumed in the first ACCEPT cycle.
- pix_sof asserted on pixel 7 of a frame: no window is produced until two further rows and 3 columns have arrived.
- Reset asserted at idx 5 of a window: win_valid=0 in the next cycle, and the next frame produces correct windows from idx 0.
- WIN_POS_EN defined, IMG_W=4 frame of 4 rows: four windows with (win_x, win_y) = (1,1), (2,1), (1,2), (2,2).
